// File: rtl/mem_dumper_pkg.sv
// Shared definitions for the memory dumper: port widths and FSM state encoding.
// The encoding matches the one used by the controller and the program loader.
package mem_dumper_pkg;

    localparam int MD_ADDR_WIDTH = 8;
    localparam int MD_DATA_WIDTH = 8;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ADDR    = 3'd1;
    localparam logic [2:0] ST_STROBE  = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_SEND    = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

endpackage

// File: rtl/mem_dumper.sv
// Walks an inclusive address range, reading one byte every 4 cycles through the strobe protocol.
// Each byte is held on a valid/ready stream; a stalled consumer freezes the walk with no memory activity.
module mem_dumper
    import mem_dumper_pkg::*;
#(
    parameter int ADDR_WIDTH = MD_ADDR_WIDTH,
    parameter int DATA_WIDTH = MD_DATA_WIDTH
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [ADDR_WIDTH-1:0] i_start_addr,
    input  logic [ADDR_WIDTH-1:0] i_last_addr,
    output logic                  o_mem_clock,
    output logic                  o_mem_write,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_to,
    input  logic [DATA_WIDTH-1:0] i_mem_from,
    output logic [DATA_WIDTH-1:0] o_out_data,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic                  o_busy,
    output logic                  o_done
);

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_cur;
    logic [ADDR_WIDTH-1:0] r_last;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [ADDR_WIDTH-1:0] w_cur_inc;

    // Natural overflow gives the wrap from the top address back to zero.
    assign w_cur_inc = r_cur + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_cur      <= '0;
            r_last     <= '0;
            r_out_data <= '0;
        end else if (i_abort && (r_state != ST_IDLE)) begin
            // Abort beats a same-cycle handshake: the pending byte counts as not sent.
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_cur   <= i_start_addr;
                        r_last  <= i_last_addr;
                        r_state <= ST_ADDR;
                    end
                end
                ST_ADDR:    r_state <= ST_STROBE;
                ST_STROBE:  r_state <= ST_CAPTURE;
                ST_CAPTURE: begin
                    r_out_data <= i_mem_from;
                    r_state    <= ST_SEND;
                end
                ST_SEND: begin
                    if (i_out_ready) begin
                        if (r_cur == r_last) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_cur   <= w_cur_inc;
                            r_state <= ST_ADDR;
                        end
                    end
                end
                ST_DONE:    r_state <= ST_IDLE;
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_mem_clock = (r_state == ST_STROBE);
    assign o_mem_write = 1'b0;
    assign o_mem_addr  = r_cur;
    assign o_mem_to    = '0;
    assign o_out_data  = r_out_data;
    assign o_out_valid = (r_state == ST_SEND);
    assign o_busy      = (r_state != ST_IDLE);
    assign o_done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_mem_dumper.sv
// Bench for mem_dumper: a strobe-clocked memory model plus a range-level reference
// (expected address and byte queues built from the requested range) checked every cycle.
module tb_mem_dumper;
    import mem_dumper_pkg::*;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          out_ready = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW-1:0] last_addr = '0;
    logic          mem_clock, mem_write, out_valid, busy, done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_to, mem_from, out_data;
    logic [DW-1:0] mem [0:255];

    mem_dumper #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_start      (start),
        .i_abort      (abort),
        .i_start_addr (start_addr),
        .i_last_addr  (last_addr),
        .o_mem_clock  (mem_clock),
        .o_mem_write  (mem_write),
        .o_mem_addr   (mem_addr),
        .o_mem_to     (mem_to),
        .i_mem_from   (mem_from),
        .o_out_data   (out_data),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_busy       (busy),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    // Memory returns the addressed byte on the rising edge of its strobe.
    always @(posedge mem_clock) mem_from <= mem[mem_addr];

    int            n_vec = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            t0 = 0;
    int            first_valid = -1;
    int            strobes = 0;
    bit            m_active = 1'b0;
    logic [7:0]    exp_dat_q[$];
    logic [7:0]    exp_adr_q[$];
    logic [7:0]    rx_log[$];
    logic [7:0]    addr_log[$];
    int            hs_cyc[$];
    int            done_cyc[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm, input logic [31:0] act);
        n_vec++;
        n_err++;
        $display("FAIL %s: got %0h, expected no such event", nm, act);
    endtask

    // Per-cycle comparison of the DUT against the range-level reference.
    task automatic compare();
        if (rst) return;
        chk("mem_write", mem_write, 0);
        chk("mem_to", mem_to, 0);
        chk("busy", busy, m_active);
        if (mem_clock) begin
            strobes++;
            addr_log.push_back(mem_addr);
            if (exp_adr_q.size() == 0) fail_now("strobe_unexpected", mem_addr);
            else chk("strobe_addr", mem_addr, exp_adr_q.pop_front());
        end
        if (out_valid) begin
            if (first_valid < 0) first_valid = cyc;
            if (exp_dat_q.size() == 0) fail_now("valid_unexpected", out_data);
            else begin
                chk("out_data", out_data, exp_dat_q[0]);
                if (out_ready && !abort) begin
                    rx_log.push_back(exp_dat_q.pop_front());
                    hs_cyc.push_back(cyc);
                end
            end
        end
        if (done) begin
            done_cyc.push_back(cyc);
            chk("done_drained", exp_dat_q.size(), 0);
            chk("done_while_active", m_active, 1);
            m_active = 1'b0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic launch(input logic [7:0] s, input logic [7:0] l);
        int n;
        logic [7:0] a;
        n = ((int'(l) - int'(s)) & 255) + 1;
        exp_adr_q.delete(); exp_dat_q.delete();
        rx_log.delete(); addr_log.delete(); hs_cyc.delete(); done_cyc.delete();
        first_valid = -1;
        strobes = 0;
        for (int i = 0; i < n; i++) begin
            a = 8'(int'(s) + i);
            exp_adr_q.push_back(a);
            exp_dat_q.push_back(mem[a]);
        end
        start_addr = s;
        last_addr = l;
        start = 1'b1;
        step();
        start = 1'b0;
        m_active = 1'b1;
        t0 = cyc;
        start_addr = 8'($urandom);
        last_addr = 8'($urandom);
    endtask

    task automatic wait_done(input int rdy_pct, input bit noise, input int budget);
        int k;
        k = 0;
        while (m_active && k < budget) begin
            out_ready = ($urandom_range(99) < rdy_pct);
            if (noise && $urandom_range(5) == 0) begin
                start = 1'b1;
                start_addr = 8'($urandom);
                last_addr = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            step();
            k++;
        end
        start = 1'b0;
        if (m_active) begin
            fail_now("dump_timeout", k);
            m_active = 1'b0;
        end
        step();
    endtask

    initial begin
        logic [7:0] e4[4];
        logic [7:0] s, l;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

        // Reset: all outputs low.
        repeat (3) step();
        chk("rst_mem_clock", mem_clock, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_out_data", out_data, 0);
        rst = 1'b0;
        step();

        // Basic four-byte dump with exact timing.
        mem[8'h10] = 8'hA1; mem[8'h11] = 8'hB2; mem[8'h12] = 8'hC3; mem[8'h13] = 8'hD4;
        out_ready = 1'b1;
        launch(8'h10, 8'h13);
        wait_done(100, 0, 100);
        e4 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        chk("t1_count", rx_log.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("t1_byte%0d", i), rx_log[i], e4[i]);
        chk("t1_first_valid", first_valid - t0, 3);
        for (int i = 0; i < 4; i++) chk($sformatf("t1_hs%0d", i), hs_cyc[i] - t0, 3 + 4 * i);
        chk("t1_done_count", done_cyc.size(), 1);
        chk("t1_done_cycle", done_cyc[0] - t0, 16);

        // Single-byte range.
        mem[8'h7F] = 8'h5A;
        launch(8'h7F, 8'h7F);
        wait_done(100, 0, 50);
        chk("t2_count", rx_log.size(), 1);
        chk("t2_byte", rx_log[0], 8'h5A);
        chk("t2_strobes", strobes, 1);
        chk("t2_done_cycle", done_cyc[0] - t0, 4);

        // Range wrapping through address zero.
        mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33; mem[8'h01] = 8'h44;
        launch(8'hFE, 8'h01);
        wait_done(100, 0, 100);
        e4 = '{8'h11, 8'h22, 8'h33, 8'h44};
        chk("t3_count", rx_log.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("t3_byte%0d", i), rx_log[i], e4[i]);
        e4 = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        for (int i = 0; i < 4; i++) chk($sformatf("t3_addr%0d", i), addr_log[i], e4[i]);

        // Consumer stall on the first byte.
        mem[8'h20] = 8'h55; mem[8'h21] = 8'h66;
        out_ready = 1'b0;
        launch(8'h20, 8'h21);
        for (int k = 0; k < 20 && !out_valid; k++) step();
        for (int k = 0; k < 10; k++) begin
            step();
            chk("t4_hold_valid", out_valid, 1);
            chk("t4_hold_data", out_data, 8'h55);
            chk("t4_hold_strobe", mem_clock, 0);
        end
        wait_done(100, 0, 50);
        chk("t4_count", rx_log.size(), 2);
        chk("t4_byte1", rx_log[1], 8'h66);

        // Abort during the second SEND, then a fresh dump.
        mem[8'h40] = 8'h01; mem[8'h41] = 8'h02; mem[8'h42] = 8'h03;
        out_ready = 1'b1;
        launch(8'h30, 8'h33);
        for (int k = 0; k < 50 && !(hs_cyc.size() == 1 && out_valid); k++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        exp_dat_q.delete(); exp_adr_q.delete();
        m_active = 1'b0;
        chk("t5_valid", out_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_sent", rx_log.size(), 1);
        repeat (5) step();
        chk("t5_no_done", done_cyc.size(), 0);
        launch(8'h40, 8'h42);
        wait_done(100, 0, 100);
        chk("t5_count", rx_log.size(), 3);
        for (int i = 0; i < 3; i++) chk($sformatf("t5_byte%0d", i), rx_log[i], 8'(i + 1));

        // Reset in the middle of a strobe.
        launch(8'h60, 8'h63);
        for (int k = 0; k < 20 && !mem_clock; k++) step();
        rst = 1'b1;
        step();
        chk("t6_mem_clock", mem_clock, 0);
        chk("t6_busy", busy, 0);
        chk("t6_valid", out_valid, 0);
        chk("t6_done", done, 0);
        chk("t6_mem_addr", mem_addr, 0);
        chk("t6_out_data", out_data, 0);
        rst = 1'b0;
        exp_dat_q.delete(); exp_adr_q.delete();
        m_active = 1'b0;
        step();

        // Start pulses while busy are ignored.
        launch(8'h50, 8'h53);
        wait_done(100, 1, 100);
        chk("t7_count", rx_log.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("t7_addr%0d", i), addr_log[i], 8'(8'h50 + i));

        // Randomized ranges, ready patterns and start noise.
        for (int it = 0; it < 30; it++) begin
            s = 8'($urandom);
            l = 8'(int'(s) + $urandom_range(9));
            launch(s, l);
            wait_done($urandom_range(30, 100), 1, 400);
            chk("rand_count", rx_log.size(), ((int'(l) - int'(s)) & 255) + 1);
        end

        // Full address space.
        launch(8'h00, 8'hFF);
        wait_done(100, 0, 1100);
        chk("full_count", rx_log.size(), 256);
        chk("full_strobes", strobes, 256);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
